// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble -> active-low segment decoder.
// Ports: nib (value 0-15), seg (pattern); HEX_MODE=0 blanks 10-15.
module hex_seg_decoder
  import seven_seg_pkg::*;
#(
  parameter bit HEX_MODE = 1'b1
) (
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = HEX_MODE ? SEG_A : SEG_BLANK;
      4'hB: seg = HEX_MODE ? SEG_B : SEG_BLANK;
      4'hC: seg = HEX_MODE ? SEG_C : SEG_BLANK;
      4'hD: seg = HEX_MODE ? SEG_D : SEG_BLANK;
      4'hE: seg = HEX_MODE ? SEG_E : SEG_BLANK;
      4'hF: seg = HEX_MODE ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed N-digit common-anode driver, double-buffered load port.
// Ports: clk, reset_n, load_valid/ready, digits_in, digit_en_in -> seg_n, digit_sel_n, frame_start.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 16,
  parameter bit HEX_MODE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  output seg_t                    seg_n,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_start
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int PW = $clog2(MAXC + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam scan_state_t FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] BLANK_LAST =
    PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Counters track the position the next registered output cycle shows.
  scan_state_t state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [IW-1:0] idx, idx_nxt;

  logic [4*NUM_DIGITS-1:0] act_dig, pend_dig, cur_dig;
  logic [NUM_DIGITS-1:0]   act_en, pend_en, cur_en;
  logic [NUM_DIGITS-1:0]   onehot, sel_nxt;
  logic [3:0]              nib;
  seg_t                    dec_seg, seg_nxt;
  logic                    frame_edge, commit, accept, en_bit;

  assign frame_edge = (state == FIRST) && (idx == '0) && (phase == '0);
  assign commit     = frame_edge && !load_ready;
  assign accept     = load_valid && load_ready;

  // On a commit edge slot 0 must already see the pending data.
  assign cur_dig = commit ? pend_dig : act_dig;
  assign cur_en  = commit ? pend_en : act_en;
  assign onehot  = NUM_DIGITS'(1) << idx;
  assign nib     = 4'(cur_dig >> {idx, 2'b00});
  assign en_bit  = |(cur_en & onehot);

  hex_seg_decoder #(
    .HEX_MODE(HEX_MODE)
  ) u_dec (
    .nib(nib),
    .seg(dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FIRST;
      phase <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase + PW'(1);
    idx_nxt   = idx;
    seg_nxt   = SEG_BLANK;
    sel_nxt   = '1;
    unique case (state)
      BLANK: begin
        if (phase == BLANK_LAST) begin
          state_nxt = SHOW;
          phase_nxt = '0;
        end
      end
      SHOW: begin
        if (en_bit) begin
          seg_nxt = dec_seg;
          sel_nxt = ~onehot;
        end
        if (phase == DWELL_LAST) begin
          state_nxt = FIRST;
          phase_nxt = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
      end
      default: state_nxt = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n       <= SEG_BLANK;
      digit_sel_n <= '1;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= seg_nxt;
      digit_sel_n <= sel_nxt;
      frame_start <= frame_edge;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_dig    <= '0;
      act_en     <= '0;
      pend_dig   <= '0;
      pend_en    <= '0;
      load_ready <= 1'b1;
    end else begin
      if (commit) begin
        act_dig    <= pend_dig;
        act_en     <= pend_en;
        load_ready <= 1'b1;
      end else if (accept) begin
        pend_dig   <= digits_in;
        pend_en    <= digit_en_in;
        load_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver (2 digits, dwell 4, blank 1).
// Second instance runs HEX_MODE=0 on the same stimulus.
module tb_seven_seg_mux_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] digits_in;
  logic [1:0] digit_en_in;

  logic       load_ready, frame_start;
  logic [6:0] seg_n;
  logic [1:0] digit_sel_n;
  logic       rdy_h, fs_h;
  logic [6:0] seg_h;
  logic [1:0] sel_h;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] BLK = 7'h7F;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(
    .NUM_DIGITS(2), .DWELL_CYCLES(4),
    .BLANK_CYCLES(1), .HEX_MODE(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .digits_in(digits_in), .digit_en_in(digit_en_in),
    .seg_n(seg_n), .digit_sel_n(digit_sel_n),
    .frame_start(frame_start)
  );

  seven_seg_mux_driver #(
    .NUM_DIGITS(2), .DWELL_CYCLES(4),
    .BLANK_CYCLES(1), .HEX_MODE(1'b0)
  ) u_hex (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(rdy_h),
    .digits_in(digits_in), .digit_en_in(digit_en_in),
    .seg_n(seg_h), .digit_sel_n(sel_h),
    .frame_start(fs_h)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = frame_start;
    end
    check({tag, "_frame_to"}, 32'(found), 32'd1);
  endtask

  // Called on the frame_start cycle; ends on frame offset 9.
  task automatic check_frame(input string tag, input bit use_hex,
                             input logic [1:0] s0_sel,
                             input logic [6:0] s0_seg,
                             input logic [1:0] s1_sel,
                             input logic [6:0] s1_seg);
    logic [1:0] sel, esel;
    logic [6:0] seg, eseg;
    for (int c = 0; c < 10; c++) begin
      sel = use_hex ? sel_h : digit_sel_n;
      seg = use_hex ? seg_h : seg_n;
      if (c == 0 || c == 5) begin
        esel = 2'b11;
        eseg = BLK;
      end else if (c < 5) begin
        esel = s0_sel;
        eseg = s0_seg;
      end else begin
        esel = s1_sel;
        eseg = s1_seg;
      end
      if (c == 0 || c == 1 || c == 4 ||
          c == 5 || c == 6 || c == 9) begin
        check($sformatf("%s_sel%0d", tag, c), 32'(sel), 32'(esel));
        check($sformatf("%s_seg%0d", tag, c), 32'(seg), 32'(eseg));
      end
      if (c < 9) @(negedge clk);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic [1:0] en);
    load_valid  = 1'b1;
    digits_in   = d;
    digit_en_in = en;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  dark;
    reset_n     = 1'b0;
    load_valid  = 1'b0;
    digits_in   = 8'h00;
    digit_en_in = 2'b00;

    #12;
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_sel", 32'(digit_sel_n), 32'h3);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_rdy", 32'(load_ready), 32'd1);
    check("rst_fs_h", 32'(fs_h), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("fs_cycle1", 32'(frame_start), 32'd1);

    cnt  = 0;
    dark = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (digit_sel_n != 2'b11 || seg_n != BLK) dark = 1'b0;
      if (frame_start) break;
    end
    check("fs_period", 32'(cnt), 32'd10);
    check("idle_dark", 32'(dark), 32'd1);

    // Mid-frame load: old (dark) data stays until next frame.
    repeat (3) @(negedge clk);
    load(8'h3A, 2'b11);
    check("3a_rdy_low", 32'(load_ready), 32'd0);
    check("3a_old_sel", 32'(digit_sel_n), 32'h3);
    wait_frame("3a");
    check("3a_rdy_hi", 32'(load_ready), 32'd1);
    check_frame("3a", 1'b0, 2'b10, 7'b0001000, 2'b01, 7'b0110000);

    // Accept on the slot-0 start edge defers commit by one frame.
    load(8'hC7, 2'b11);
    check("c7_defer_fs", 32'(frame_start), 32'd1);
    check("c7_defer_rdy", 32'(load_ready), 32'd0);
    check_frame("c7_old", 1'b0, 2'b10, 7'b0001000, 2'b01, 7'b0110000);
    wait_frame("c7");
    check("c7_rdy_hi", 32'(rdy_h), 32'd1);
    check_frame("c7_hex0", 1'b1, 2'b10, 7'b1111000, 2'b01, 7'b1111111);
    wait_frame("c7b");
    check_frame("c7_hex1", 1'b0, 2'b10, 7'b1111000, 2'b01, 7'b1000110);

    // Digit 0 disabled.
    repeat (2) @(negedge clk);
    load(8'h55, 2'b10);
    wait_frame("55");
    check_frame("55", 1'b0, 2'b11, BLK, 2'b01, 7'b0010010);

    // Second offer while not ready is held off.
    repeat (2) @(negedge clk);
    load(8'h12, 2'b11);
    check("12_rdy_low", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    digits_in  = 8'h99;
    wait_frame("12");
    check_frame("12", 1'b0, 2'b10, 7'b0100100, 2'b01, 7'b1111001);
    load_valid = 1'b0;
    check("99_rdy_low", 32'(load_ready), 32'd0);
    wait_frame("99");
    check("99_rdy_hi", 32'(load_ready), 32'd1);
    check_frame("99", 1'b0, 2'b10, 7'b0010000, 2'b01, 7'b0010000);

    // Asynchronous reset during SHOW with a pending load.
    repeat (2) @(negedge clk);
    load(8'h44, 2'b11);
    check("ar_pend", 32'(load_ready), 32'd0);
    check("ar_show", 32'(digit_sel_n), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_seg", 32'(seg_n), 32'h7F);
    check("ar_sel", 32'(digit_sel_n), 32'h3);
    check("ar_fs", 32'(frame_start), 32'd0);
    check("ar_rdy", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    wait_frame("ar");
    check("ar_rdy_after", 32'(load_ready), 32'd1);
    check_frame("ar", 1'b0, 2'b11, BLK, 2'b11, BLK);
    wait_frame("ar2");
    check_frame("ar2", 1'b0, 2'b11, BLK, 2'b11, BLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Decodes full hex (0-F); decimal-only mode is available.
- Scans digits one-hot with programmable dwell time.
- Inserts anti-ghosting blank cycles between digits.
- Double-buffers digit data behind a valid/ready load port, so updates apply only at frame boundaries (no tearing).
- Sits between user logic (counters, switch inputs) and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (1..8)
DWELL_CYCLES, 4096, clocks each digit is driven per slot (>=1)
BLANK_CYCLES, 16, clocks all digits are off before each digit's dwell (>=0)
HEX_MODE, 1, 1 = decode A-F; 0 = values 10-15 display blank

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
load_valid  in  1  new digit data offered
load_ready  out  1  pending buffer empty, can accept
digits_in  in  4*NUM_DIGITS  nibble k = digit k value (digit 0 = LSN)
digit_en_in  in  NUM_DIGITS  per-digit enable; 0 = digit dark
seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
digit_sel_n  out  NUM_DIGITS  active-low one-hot digit select
frame_start  out  1  one-cycle pulse on first cycle of slot 0

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - seg_n=7'h7F, digit_sel_n all 1, frame_start=0, load_ready=1.
  - Active and pending buffers: values 0, enables 0.
  - Slot index 0; phase counter 0.
- All outputs are registered; decode is combinational from the active buffer into the output register.
- Slot timing:
  - One slot = BLANK_CYCLES + DWELL_CYCLES clocks; one frame = NUM_DIGITS slots.
  - Slot k, BLANK phase (BLANK_CYCLES clocks): digit_sel_n all 1, seg_n=7'h7F.
  - Slot k, SHOW phase (DWELL_CYCLES clocks): digit_sel_n bit k=0, others 1; seg_n=decode(digit k).
  - If BLANK_CYCLES=0, the BLANK phase is skipped entirely.
- FSM states BLANK and SHOW:
  - BLANK -> SHOW after BLANK_CYCLES clocks.
  - SHOW -> BLANK (or SHOW of the next slot if BLANK_CYCLES=0) after DWELL_CYCLES clocks.
  - Slot index increments modulo NUM_DIGITS at end of SHOW; wraps NUM_DIGITS-1 -> 0.
- First cycle after reset release: first output cycle of slot 0. frame_start=1 in that cycle.
- Disabled digit (enable=0): slot timing is unchanged, but digit_sel_n stays all 1 and seg_n=7'h7F for the whole slot.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - HEX_MODE=0: values 10-15 produce 1111111.
- Load handshake:
  - Transfer occurs when load_valid & load_ready at a rising edge.
  - digits_in and digit_en_in are captured into the pending buffer.
  - load_ready drops to 0 on the next cycle.
- Commit:
  - On the clock edge that begins slot 0, if pending is full, pending is copied to active and load_ready returns to 1.
  - The slot 0 display already uses the new data.
  - An accept on the same edge as a slot-0 start does not commit until the following frame.
- load_valid while load_ready=0: ignored. The source must hold its data; nothing is overwritten.
- Reset mid-frame: all outputs go immediately (asynchronously) to reset values. A pending load is discarded.
- Counters: phase counter is $clog2(max(DWELL,BLANK)+1) bits; index is $clog2(NUM_DIGITS) bits, minimum 1. No counter may overflow.

Decomposition:
- Package seven_seg_pkg contains:
  - typedef seg_t (logic [6:0])
  - SEG_BLANK = 7'h7F
  - the 16 glyph constants
  - typedef scan_state_t {BLANK, SHOW}
- Sub-module hex_seg_decoder (combinational nibble -> seg_t, parameter HEX_MODE). It is instantiated once on the selected nibble.

Test Plan:
All tests use NUM_DIGITS=2, DWELL=4, BLANK=1.
- Reset then release; hold no load -> frame_start at cycle 1, period 10; digit_sel_n stays 2'b11 and seg_n stays 7F throughout (enables=0).
- Load digits_in=8'h3A, en=2'b11 mid-frame -> load_ready=0 the next cycle; old data is shown until the next frame_start. Then, per frame:
  - 1 blank cycle
  - 4 cycles of digit_sel_n=10, seg_n=0001000 (A)
  - 1 blank cycle
  - 4 cycles of digit_sel_n=01, seg_n=0110000 (3)
  - load_ready=1 after the commit.
- HEX_MODE=0, load 8'hC7, en=11 -> digit 0 slot shows 1111000; digit 1 slot asserts select with seg_n=1111111.
- Load en=2'b10 value 8'h55 -> slot 0 fully dark; slot 1 shows 0010010 with digit_sel_n=01.
- Second load_valid while load_ready=0 (value 8'h99) -> ignored; only the first value commits, then 8'h99 is accepted after ready rises.
- Assert reset_n=0 during SHOW with a pending load -> outputs are reset asynchronously (before next clk); after release, active data is blank and load_ready=1.
